// File: rtl/fb_write_arbiter_pkg.sv
// Shared framebuffer geometry and arbiter state type.
// The drawing engines use these constants as well as the write arbiter.
package fb_pkg;

    localparam int unsigned FB_WIDTH  = 160;
    localparam int unsigned FB_HEIGHT = 120;
    localparam int unsigned FB_PIXELS = FB_WIDTH * FB_HEIGHT;
    localparam int unsigned FB_ADDRW  = 15;
    localparam int unsigned FB_DATAW  = 4;

    typedef enum logic [0:0] {
        IDLE,
        CLEAR
    } fb_arb_state_t;

    // An index into n items needs at least one bit, even when n is 1.
    function automatic int unsigned idx_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/fb_write_arbiter_if.sv
// Requester-side bundle for the framebuffer write arbiter: valid/ready per engine
// plus the packed addresses and colour indices.
interface fb_write_arbiter_if #(
    parameter int unsigned NREQ  = 2,
    parameter int unsigned ADDRW = 15,
    parameter int unsigned DATAW = 4
);

    logic [NREQ-1:0]       req_valid;
    logic [NREQ-1:0]       req_ready;
    logic [NREQ*ADDRW-1:0] req_addr;
    logic [NREQ*DATAW-1:0] req_cidx;

    modport master (
        output req_valid,
        output req_addr,
        output req_cidx,
        input  req_ready
    );

    modport slave (
        input  req_valid,
        input  req_addr,
        input  req_cidx,
        output req_ready
    );

endinterface

// File: rtl/fb_write_arbiter_rr_arbiter.sv
// Combinational round-robin picker: the search starts one slot after ptr and
// returns a one-hot grant plus its index. The pointer register lives in the parent.
module rr_arbiter
    import fb_pkg::*;
#(
    parameter int unsigned N = 2,
    localparam int unsigned IW = idx_width(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    input  logic          enable,
    output logic [N-1:0]  gnt,
    output logic [IW-1:0] gnt_idx
);

    always_comb begin
        int unsigned idx;
        logic [IW-1:0] sel;
        logic found;
        gnt     = '0;
        gnt_idx = '0;
        found   = 1'b0;
        idx     = 0;
        sel     = '0;
        for (int unsigned k = 0; k < N; k++) begin
            idx = (32'(ptr) + 32'd1 + k) % N;
            sel = IW'(idx);
            if (enable && !found && req[sel]) begin
                found    = 1'b1;
                gnt[sel] = 1'b1;
                gnt_idx  = sel;
            end
        end
    end

endmodule

// File: rtl/fb_write_arbiter.sv
// Owns the framebuffer BRAM write port: round-robin arbitration between drawing
// engines plus a full-buffer clear sequencer. Optional macro: FB_WRITE_ARB_VBI_GATE_EN.
module fb_write_arbiter
    import fb_pkg::*;
#(
    parameter int unsigned NREQ      = 2,
    parameter int unsigned FB_PIXELS = 19200,
    parameter int unsigned ADDRW     = 15,
    parameter int unsigned DATAW     = 4,
    localparam int unsigned GW = idx_width(NREQ)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    fb_write_arbiter_if.slave    req,
    input  logic                 clr_start,
    input  logic [DATAW-1:0]     clr_cidx,
    output logic                 clr_busy,
    output logic                 clr_done,
    input  logic                 vbi,
    output logic                 fb_we,
    output logic [ADDRW-1:0]     fb_addr,
    output logic [DATAW-1:0]     fb_cidx,
    output logic [GW-1:0]        grant_id
);

    localparam logic [ADDRW-1:0] LAST_ADDR = ADDRW'(FB_PIXELS - 1);

    fb_arb_state_t    state, state_next;
    logic [GW-1:0]    ptr;
    logic [ADDRW-1:0] cnt;
    logic [DATAW-1:0] clr_val;
    logic [NREQ-1:0]  gnt;
    logic [GW-1:0]    gnt_idx;
    logic             arb_en;
    logic             clr_go;
    logic             gate;

`ifdef FB_WRITE_ARB_VBI_GATE_EN
    assign gate = vbi;
`else
    logic unused_vbi;
    assign unused_vbi = vbi;
    assign gate       = 1'b1;
`endif

    rr_arbiter #(.N(NREQ)) u_rr (
        .req     (req.req_valid),
        .ptr     (ptr),
        .enable  (arb_en),
        .gnt     (gnt),
        .gnt_idx (gnt_idx)
    );

    assign req.req_ready = gnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    // A clear request pre-empts arbitration in the same cycle.
    always_comb begin
        state_next = state;
        clr_go     = 1'b0;
        arb_en     = 1'b0;
        case (state)
            IDLE: begin
                clr_go = clr_start & gate;
                arb_en = gate & ~clr_go;
                if (clr_go) state_next = CLEAR;
            end
            CLEAR: begin
                if (cnt == LAST_ADDR) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fb_we    <= 1'b0;
            fb_addr  <= '0;
            fb_cidx  <= '0;
            clr_busy <= 1'b0;
            clr_done <= 1'b0;
            grant_id <= '0;
            ptr      <= GW'(NREQ - 1);
            cnt      <= '0;
            clr_val  <= '0;
        end else begin
            clr_done <= 1'b0;
            if (state == CLEAR) begin
                fb_we   <= 1'b1;
                fb_addr <= cnt;
                fb_cidx <= clr_val;
                if (cnt == LAST_ADDR) begin
                    clr_busy <= 1'b0;
                    clr_done <= 1'b1;
                end else begin
                    cnt <= cnt + 1'b1;
                end
            end else if (clr_go) begin
                fb_we    <= 1'b0;
                cnt      <= '0;
                clr_val  <= clr_cidx;
                clr_busy <= 1'b1;
            end else if (|gnt) begin
                fb_we    <= 1'b1;
                fb_addr  <= req.req_addr[gnt_idx*ADDRW +: ADDRW];
                fb_cidx  <= req.req_cidx[gnt_idx*DATAW +: DATAW];
                ptr      <= gnt_idx;
                grant_id <= gnt_idx;
            end else begin
                fb_we <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_fb_write_arbiter.sv
// Self-checking bench for fb_write_arbiter: directed scenarios plus randomized
// requester traffic, all compared every cycle against a behavioural model.
module tb_fb_write_arbiter;

    localparam int NREQ = 2;
    localparam int FBP  = 19200;
    localparam int AW   = 15;
    localparam int DW   = 4;

    logic          clk;
    logic          rst_n;
    logic          clr_start;
    logic [DW-1:0] clr_cidx;
    logic          clr_busy;
    logic          clr_done;
    logic          vbi;
    logic          fb_we;
    logic [AW-1:0] fb_addr;
    logic [DW-1:0] fb_cidx;
    logic [0:0]    grant_id;

    fb_write_arbiter_if #(.NREQ(NREQ), .ADDRW(AW), .DATAW(DW)) bus ();

    fb_write_arbiter #(
        .NREQ      (NREQ),
        .FB_PIXELS (FBP),
        .ADDRW     (AW),
        .DATAW     (DW)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (bus),
        .clr_start (clr_start),
        .clr_cidx  (clr_cidx),
        .clr_busy  (clr_busy),
        .clr_done  (clr_done),
        .vbi       (vbi),
        .fb_we     (fb_we),
        .fb_addr   (fb_addr),
        .fb_cidx   (fb_cidx),
        .grant_id  (grant_id)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    task automatic chk(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Requester stimulus, packed onto the interface by apply()
    bit v[NREQ];
    int a[NREQ];
    int c[NREQ];

    task automatic apply();
        for (int i = 0; i < NREQ; i++) begin
            bus.req_valid[i]          = v[i];
            bus.req_addr[i*AW +: AW]  = AW'(a[i]);
            bus.req_cidx[i*DW +: DW]  = DW'(c[i]);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic bit gate_ok();
`ifdef FB_WRITE_ARB_VBI_GATE_EN
        return vbi;
`else
        return 1'b1;
`endif
    endfunction

    // Behavioural model: the registered outputs it predicts for the next cycle
    int m_ptr, m_next, m_val, m_addr, m_cidx, m_gid;
    bit m_clr, m_we, m_busy, m_done;

    task automatic model_reset();
        m_ptr = NREQ - 1; m_clr = 0; m_next = 0; m_val = 0;
        m_we = 0; m_addr = 0; m_cidx = 0; m_busy = 0; m_done = 0; m_gid = 0;
    endtask

    initial model_reset();

    always @(negedge clk) begin
        int w;
        int exp_rdy;
        if (!rst_n) model_reset();
        w = -1;
        if (!m_clr && !(clr_start && gate_ok()) && gate_ok()) begin
            for (int k = 0; k < NREQ; k++) begin
                int i;
                i = (m_ptr + 1 + k) % NREQ;
                if (w < 0 && bus.req_valid[i]) w = i;
            end
        end
        exp_rdy = (w >= 0) ? (1 << w) : 0;
        chk("req_ready", int'(bus.req_ready), exp_rdy);
        chk("fb_we",     int'(fb_we),    int'(m_we));
        chk("fb_addr",   int'(fb_addr),  m_addr);
        chk("fb_cidx",   int'(fb_cidx),  m_cidx);
        chk("clr_busy",  int'(clr_busy), int'(m_busy));
        chk("clr_done",  int'(clr_done), int'(m_done));
        chk("grant_id",  int'(grant_id), m_gid);
        if (rst_n) begin
            m_done = 0;
            if (m_clr) begin
                m_we = 1; m_addr = m_next; m_cidx = m_val;
                if (m_next == FBP - 1) begin
                    m_clr = 0; m_busy = 0; m_done = 1;
                end else begin
                    m_next++;
                end
            end else if (clr_start && gate_ok()) begin
                m_clr = 1; m_next = 0; m_val = int'(clr_cidx); m_busy = 1; m_we = 0;
            end else if (w >= 0) begin
                m_we   = 1;
                m_addr = int'(bus.req_addr[w*AW +: AW]);
                m_cidx = int'(bus.req_cidx[w*DW +: DW]);
                m_ptr  = w;
                m_gid  = w;
            end else begin
                m_we = 0;
            end
        end
    end

    // Runs a clear pass (already started), optionally re-pulsing clr_start at
    // cycle 'repulse'; reports writes seen and clr_done pulses.
    task automatic run_clear(input int repulse, output int writes, output int dones,
                             output int last_addr, output int rdy_at_done);
        bit fin;
        writes = 0; dones = 0; last_addr = -1; rdy_at_done = -1; fin = 0;
        for (int n = 0; n < FBP + 100 && !fin; n++) begin
            @(negedge clk);
            if (fb_we && (clr_busy || clr_done) && fb_cidx == clr_cidx) writes++;
            if (clr_done) begin
                dones++;
                last_addr   = int'(fb_addr);
                rdy_at_done = int'(bus.req_ready);
                fin = 1;
            end else begin
                step();
                clr_start = (n == repulse);
            end
        end
        chk("clear_finished_in_time", int'(fin), 1);
        clr_start = 0;
    endtask

    initial begin
        int writes, dones, last_addr, rdy;
        bit [NREQ-1:0] acc;

        rst_n = 0; clr_start = 0; clr_cidx = '0; vbi = 1;
        for (int i = 0; i < NREQ; i++) begin v[i] = 0; a[i] = 0; c[i] = 0; end
        apply();
        repeat (2) @(negedge clk);
        chk("reset_fb_we", int'(fb_we), 0);
        chk("reset_grant_id", int'(grant_id), 0);
        step();
        rst_n = 1;

        // Both engines held valid: grants alternate starting with requester 0
        v[0] = 1; a[0] = 10; c[0] = 1;
        v[1] = 1; a[1] = 20; c[1] = 2;
        apply();
        for (int n = 0; n < 4; n++) begin
            @(negedge clk);
            chk("alt_ready", int'(bus.req_ready), (n % 2 == 0) ? 1 : 2);
            if (n == 1) chk("alt_addr0", int'(fb_addr), 10);
            if (n == 2) chk("alt_addr1", int'(fb_addr), 20);
            if (n >= 1) chk("alt_we", int'(fb_we), 1);
            step();
        end
        v[0] = 0; v[1] = 0; apply();
        step();

        // Lone requester 1, five back-to-back transfers
        for (int k = 0; k < 5; k++) begin
            v[1] = 1; a[1] = 100 + k; c[1] = 7; apply();
            step();
        end
        v[1] = 0; apply();
        @(negedge clk);
        chk("single_last_addr", int'(fb_addr), 104);
        chk("single_last_we", int'(fb_we), 1);
        chk("single_gid", int'(grant_id), 1);
        step();
        @(negedge clk);
        chk("single_we_drop", int'(fb_we), 0);
        step();

        // Clear colliding with a request: clear wins, request served afterwards
        clr_start = 1; clr_cidx = 4'h3;
        v[0] = 1; a[0] = 555; c[0] = 9; apply();
        @(negedge clk);
        chk("clr_collide_ready", int'(bus.req_ready), 0);
        step();
        clr_start = 0;
        run_clear(-1, writes, dones, last_addr, rdy);
        chk("clr1_writes", writes, FBP);
        chk("clr1_dones", dones, 1);
        chk("clr1_last_addr", last_addr, FBP - 1);
        chk("clr1_ready_after", rdy, 1);
        step();
        v[0] = 0; apply();
        @(negedge clk);
        chk("post_clr_addr", int'(fb_addr), 555);
        chk("post_clr_cidx", int'(fb_cidx), 9);
        step();

        // Second clr_start during a clear is ignored
        clr_start = 1; clr_cidx = 4'hA;
        step();
        clr_start = 0;
        run_clear(50, writes, dones, last_addr, rdy);
        chk("clr2_writes", writes, FBP);
        chk("clr2_dones", dones, 1);
        dones = 0;
        for (int n = 0; n < 5; n++) begin
            step();
            @(negedge clk);
            if (clr_done) dones++;
        end
        chk("clr2_no_extra_done", dones, 0);
        step();

        // Reset in the middle of a clear abandons it
        clr_start = 1; clr_cidx = 4'h5;
        step();
        clr_start = 0;
        begin
            bit hit;
            hit = 0;
            for (int n = 0; n < FBP && !hit; n++) begin
                @(negedge clk);
                if (fb_we && int'(fb_addr) == 5000) hit = 1;
            end
            chk("reached_addr_5000", int'(hit), 1);
        end
        @(posedge clk);
        #3 rst_n = 0;
        #1;
        chk("arst_we", int'(fb_we), 0);
        chk("arst_addr", int'(fb_addr), 0);
        chk("arst_cidx", int'(fb_cidx), 0);
        chk("arst_busy", int'(clr_busy), 0);
        chk("arst_done", int'(clr_done), 0);
        chk("arst_gid", int'(grant_id), 0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1;
        v[0] = 1; v[1] = 1; a[0] = 7; a[1] = 8; apply();
        @(negedge clk);
        chk("post_rst_first_winner", int'(bus.req_ready), 1);
        chk("post_rst_no_done", int'(clr_done), 0);
        step();
        v[0] = 0; v[1] = 0; apply();
        step();

`ifdef FB_WRITE_ARB_VBI_GATE_EN
        vbi = 0; v[0] = 1; a[0] = 42; apply();
        for (int n = 0; n < 10; n++) begin
            @(negedge clk);
            chk("vbi_blocked", int'(bus.req_ready), 0);
            step();
        end
        vbi = 1;
        #1;
        @(negedge clk);
        chk("vbi_open", int'(bus.req_ready), 1);
        step();
        v[0] = 0; apply();
        step();
`endif

        // Random traffic; each engine holds its request until accepted
        for (int n = 0; n < 400; n++) begin
            @(negedge clk);
            acc = bus.req_valid & bus.req_ready;
            step();
            for (int i = 0; i < NREQ; i++) begin
                if (!v[i] || acc[i]) begin
                    v[i] = 1'($urandom_range(0, 1));
                    a[i] = int'($urandom_range(0, 32767));
                    c[i] = int'($urandom_range(0, 15));
                end
            end
            vbi = ($urandom_range(0, 3) != 0);
            apply();
        end
        v[0] = 0; v[1] = 0; apply();
        repeat (3) step();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/fb_write_arbiter.md
Name: fb_write_arbiter

Overview:
- Owns the single write port of the framebuffer BRAM (simple dual-port, pixel clock domain).
- Shares that port between NREQ drawing engines using a round-robin scheme with a valid/ready handshake per requester.
- Contains a built-in clear sequencer that fills the whole buffer with one palette index.
- Sits between the drawing engines and the bram_sdp write inputs (we / addr_write / data_in).

Parameters:
- NREQ, 2, number of drawing requesters (1..8)
- FB_PIXELS, 19200, framebuffer depth in pixels (160x120)
- ADDRW, 15, write address width; must satisfy 2**ADDRW >= FB_PIXELS
- DATAW, 4, colour-index bits per pixel

Ports:
- clk, input, 1, pixel clock; all logic in this single domain
- rst_n, input, 1, reset: asynchronous assert, active low
- req_valid, input, NREQ, per-requester write request
- req_ready, output, NREQ, per-requester accept; one-hot or zero
- req_addr, input, NREQ*ADDRW, packed write addresses; requester i at bits [i*ADDRW +: ADDRW]
- req_cidx, input, NREQ*DATAW, packed colour indices; requester i at bits [i*DATAW +: DATAW]
- clr_start, input, 1, pulse: begin a clear pass
- clr_cidx, input, DATAW, fill index; sampled on the accepted clr_start
- clr_busy, output, 1, clear pass in progress
- clr_done, output, 1, single-cycle pulse when a clear pass finishes
- vbi, input, 1, vertical blanking interval flag (used only with the optional feature)
- fb_we, output, 1, BRAM write enable
- fb_addr, output, ADDRW, BRAM write address
- fb_cidx, output, DATAW, BRAM write data
- grant_id, output, clog2(NREQ) (min 1), index of the last accepted requester

Behaviour:
- Reset: fb_we=0, fb_addr=0, fb_cidx=0, clr_busy=0, clr_done=0, grant_id=0, rr pointer=NREQ-1 (requester 0 has first priority), state=IDLE.
- FSM states: IDLE, CLEAR.
- IDLE transitions:
  - clr_start=1 → CLEAR; clear counter=0; latch clr_cidx; clr_busy=1 from the next cycle.
  - Otherwise, arbitrate among the requesters.
- Arbitration, IDLE only:
  - Search starts at (ptr+1) mod NREQ; the first i with req_valid[i] wins.
  - req_ready[i]=1 combinationally, in the same cycle.
  - A transfer occurs when valid&ready are both high.
  - On a transfer, ptr←i and grant_id←i.
  - At most one transfer per cycle. Back-to-back transfers every cycle are allowed.
- Write latency: 1 cycle. The next cycle shows fb_we=1 with the registered addr and cidx. With no transfer, fb_we=0 next cycle and fb_addr/fb_cidx hold their values.
- clr_start and any req_valid in the same IDLE cycle: clear wins; all req_ready=0 that cycle.
- CLEAR state:
  - all req_ready=0.
  - Each cycle: fb_we=1, fb_addr=counter, fb_cidx=latched index; counter increments.
  - After issuing the write for address FB_PIXELS-1: counter does not wrap, return to IDLE, clr_busy=0, clr_done=1 for exactly one cycle (coincident with the final fb_we).
  - A clear takes exactly FB_PIXELS write cycles.
  - clr_start while in CLEAR is ignored and not queued.
- Arbitration resumes in the first IDLE cycle after CLEAR. The rr pointer is preserved across the clear.
- Requesters must hold valid, addr and cidx stable until accepted. The block does not check this.
- Addresses ≥ FB_PIXELS from requesters are passed through unmodified; range checking is the requester's responsibility.
- Reset asserted mid-clear or mid-burst: immediately returns to reset values; the partial clear is abandoned with no clr_done.

Optional Feature:
- Macro: FB_WRITE_ARB_VBI_GATE_EN.
- Defined: requester grants occur only when vbi=1; with vbi=0, all req_ready=0. A clear_start is accepted only when vbi=1, but once in CLEAR the pass runs to completion regardless of vbi.
- Undefined: vbi is ignored (port remains, lint waiver); behaviour as above.

Decomposition:
- Package fb_pkg:
  - typedef enum fb_arb_state_t {IDLE, CLEAR}
  - localparams FB_WIDTH=160, FB_HEIGHT=120, FB_PIXELS, FB_ADDRW, FB_DATAW for shared use by drawing engines
- One sub-module: rr_arbiter.
  - Parameter N.
  - Inputs: req[N], ptr, enable.
  - Outputs: one-hot gnt[N], gnt_idx.
  - Purely combinational; pointer register stays in the parent.

Test Plan:
- Reset then req_valid=2'b11 held, distinct addrs: grants alternate 0,1,0,1; fb_we high each cycle from cycle 2; fb_addr/fb_cidx match the winner one cycle later.
- Single requester 1 valid for 5 cycles (addr 100..104, cidx 4'h7): 5 transfers, grant_id=1; fb_addr 100..104 appear with 1-cycle latency; fb_we drops the cycle after valid falls.
- clr_start with clr_cidx=4'h3 and req_valid=2'b01 in the same cycle: req_ready=0; next FB_PIXELS cycles write 0..19199 with cidx 3; clr_done pulses once at addr 19199; req 0 is accepted in the first IDLE cycle.
- Second clr_start 50 cycles into a clear: ignored; exactly 19200 writes and one clr_done.
- rst_n asserted at clear address 5000: all outputs 0 asynchronously; no clr_done; after release, requester 0 wins first.
- With FB_WRITE_ARB_VBI_GATE_EN: req_valid=1 and vbi=0 → req_ready=0 for 10 cycles; vbi→1 → accepted the same cycle.
